// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer control for an asynchronous FIFO: synchronises the Gray write
// pointer, advances the read pointer and derives empty/occupancy/underflow status.
module rd_ptr_ctrl #(
  parameter int unsigned PTR_WIDTH     = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                 i_rd_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rd_en,
  input  logic                 i_clr_err,
  input  logic [PTR_WIDTH:0]   i_g_wr_ptr,
  output logic [PTR_WIDTH-1:0] o_rd_addr,
  output logic [PTR_WIDTH:0]   o_b_rd_ptr,
  output logic [PTR_WIDTH:0]   o_g_rd_ptr,
  output logic                 o_empty,
  output logic                 o_almost_empty,
  output logic [PTR_WIDTH:0]   o_rd_count,
  output logic                 o_rd_ack,
  output logic                 o_underflow
);

  localparam logic [PTR_WIDTH:0] AeThresh = (PTR_WIDTH + 1)'(AEMPTY_THRESH);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (AEMPTY_THRESH > (2 ** PTR_WIDTH) - 1) begin : g_bad_aempty_thresh
    $error("AEMPTY_THRESH must be in 0..2^PTR_WIDTH-1");
  end

  logic [PTR_WIDTH:0] r_sync [SYNC_STAGES];
  logic [PTR_WIDTH:0] r_b_rd_ptr;
  logic [PTR_WIDTH:0] r_g_rd_ptr;
  logic               r_empty;
  logic               r_almost_empty;
  logic [PTR_WIDTH:0] r_rd_count;
  logic               r_rd_ack;
  logic               r_underflow;

  logic [PTR_WIDTH:0] w_g_wr_sync;
  logic [PTR_WIDTH:0] w_wr_bin;
  logic               w_rd_fire;
  logic [PTR_WIDTH:0] w_b_next;
  logic [PTR_WIDTH:0] w_g_next;
  logic [PTR_WIDTH:0] w_count_next;

  assign w_g_wr_sync = r_sync[SYNC_STAGES-1];

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wr_bin            = '0;
    w_wr_bin[PTR_WIDTH] = w_g_wr_sync[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      w_wr_bin[i] = w_wr_bin[i+1] ^ w_g_wr_sync[i];
    end
  end

  assign w_rd_fire    = i_rd_en & ~r_empty;
  assign w_b_next     = r_b_rd_ptr + {{PTR_WIDTH{1'b0}}, w_rd_fire};
  assign w_g_next     = w_b_next ^ (w_b_next >> 1);
  assign w_count_next = w_wr_bin - w_b_next;

  always_ff @(posedge i_rd_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_g_wr_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Status flags look at the post-read pointer so they already account for this cycle's read.
  always_ff @(posedge i_rd_clk) begin
    if (!i_rst_n) begin
      r_b_rd_ptr     <= '0;
      r_g_rd_ptr     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_count     <= '0;
      r_rd_ack       <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_b_rd_ptr     <= w_b_next;
      r_g_rd_ptr     <= w_g_next;
      r_empty        <= (w_g_next == w_g_wr_sync);
      r_almost_empty <= (w_count_next <= AeThresh);
      r_rd_count     <= w_count_next;
      r_rd_ack       <= w_rd_fire;
      if (i_rd_en && r_empty) begin
        r_underflow <= 1'b1;
      end else if (i_clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_rd_addr      = r_b_rd_ptr[PTR_WIDTH-1:0];
  assign o_b_rd_ptr     = r_b_rd_ptr;
  assign o_g_rd_ptr     = r_g_rd_ptr;
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;
  assign o_rd_count     = r_rd_count;
  assign o_rd_ack       = r_rd_ack;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Bench for rd_ptr_ctrl: directed vector table, wrap and mid-reset sequences, and
// randomized traffic compared against an occupancy-level reference model.
module tb_rd_ptr_ctrl;

  localparam int PW  = 4;
  localparam int SS  = 2;
  localparam int TH  = 2;
  localparam int MOD = 32;

  logic       clk = 1'b0;
  logic       rst_n, rd_en, clr_err;
  logic [4:0] g_wr;
  logic [3:0] rd_addr;
  logic [4:0] b_rd_ptr, g_rd_ptr, rd_count;
  logic       empty, almost_empty, rd_ack, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rd_ptr_ctrl #(
    .PTR_WIDTH    (PW),
    .SYNC_STAGES  (SS),
    .AEMPTY_THRESH(TH)
  ) u_dut (
    .i_rd_clk      (clk),
    .i_rst_n       (rst_n),
    .i_rd_en       (rd_en),
    .i_clr_err     (clr_err),
    .i_g_wr_ptr    (g_wr),
    .o_rd_addr     (rd_addr),
    .o_b_rd_ptr    (b_rd_ptr),
    .o_g_rd_ptr    (g_rd_ptr),
    .o_empty       (empty),
    .o_almost_empty(almost_empty),
    .o_rd_count    (rd_count),
    .o_rd_ack      (rd_ack),
    .o_underflow   (underflow)
  );

  typedef struct {
    logic       rst_n;
    logic       rd_en;
    logic       clr_err;
    logic [4:0] g_wr;
    logic       e_empty;
    logic       e_ae;
    logic [4:0] e_cnt;
    logic [4:0] e_b;
    logic [4:0] e_g;
    logic       e_ack;
    logic       e_uf;
  } vec_t;

  vec_t vecs[13];

  // Reference model: pointers as integers, write pointer visible after SS edges.
  logic [4:0] m_q[$];
  int         m_rd;
  int         m_cnt;
  bit         m_empty, m_ae, m_ack, m_uf;

  function automatic int g2b(input logic [4:0] g);
    int b = 0;
    for (int s = 0; s <= PW; s++) b = b ^ (int'(g) >> s);
    return b;
  endfunction

  task automatic model_edge(input logic r, input logic en, input logic clr,
                            input logic [4:0] g);
    int  occ;
    bit  fire, uf_set;
    logic [4:0] vis;
    if (!r) begin
      m_q = {};
      for (int i = 0; i < SS; i++) m_q.push_back(5'd0);
      m_rd = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_ack = 0; m_uf = 0;
    end else begin
      vis     = m_q[SS-1];
      fire    = en && !m_empty;
      uf_set  = en && m_empty;
      m_rd    = (m_rd + int'(fire)) % MOD;
      occ     = (g2b(vis) - m_rd + MOD) % MOD;
      m_cnt   = occ;
      m_empty = (occ == 0);
      m_ae    = (occ <= TH);
      m_ack   = fire;
      if (uf_set) m_uf = 1;
      else if (clr) m_uf = 0;
      void'(m_q.pop_back());
      m_q.push_front(g);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic clr, input logic [4:0] g);
    rst_n = r; rd_en = en; clr_err = clr; g_wr = g;
    @(posedge clk);
    model_edge(r, en, clr, g);
    #1;
  endtask

  task automatic check_model(input string tag);
    int rg;
    rg = m_rd ^ (m_rd >> 1);
    check({tag, ".b_rd_ptr"}, int'(b_rd_ptr), m_rd);
    check({tag, ".g_rd_ptr"}, int'(g_rd_ptr), rg);
    check({tag, ".rd_addr"}, int'(rd_addr), m_rd % 16);
    check({tag, ".empty"}, int'(empty), int'(m_empty));
    check({tag, ".almost_empty"}, int'(almost_empty), int'(m_ae));
    check({tag, ".rd_count"}, int'(rd_count), m_cnt);
    check({tag, ".rd_ack"}, int'(rd_ack), int'(m_ack));
    check({tag, ".underflow"}, int'(underflow), int'(m_uf));
  endtask

  initial begin
    int w;
    for (int i = 0; i < SS; i++) m_q.push_back(5'd0);
    m_rd = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_ack = 0; m_uf = 0;
    rst_n = 1'b0; rd_en = 1'b0; clr_err = 1'b0; g_wr = '0;

    // rst en clr g_wr | empty ae cnt b g ack uf
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 5'b00010, 1'b0, 1'b1, 5'd2, 5'd1, 5'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 5'b00010, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b1, 5'd0, 5'd3, 5'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'b00010, 1'b1, 1'b1, 5'd0, 5'd3, 5'd2, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 5'b00010, 1'b1, 1'b1, 5'd0, 5'd3, 5'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 5'b00010, 1'b1, 1'b1, 5'd0, 5'd3, 5'd2, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b1, 5'd0, 5'd3, 5'd2, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 5'b00010, 1'b1, 1'b1, 5'd0, 5'd3, 5'd2, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].rst_n, vecs[i].rd_en, vecs[i].clr_err, vecs[i].g_wr);
      check({t, ".empty"}, int'(empty), int'(vecs[i].e_empty));
      check({t, ".almost_empty"}, int'(almost_empty), int'(vecs[i].e_ae));
      check({t, ".rd_count"}, int'(rd_count), int'(vecs[i].e_cnt));
      check({t, ".b_rd_ptr"}, int'(b_rd_ptr), int'(vecs[i].e_b));
      check({t, ".g_rd_ptr"}, int'(g_rd_ptr), int'(vecs[i].e_g));
      check({t, ".rd_ack"}, int'(rd_ack), int'(vecs[i].e_ack));
      check({t, ".underflow"}, int'(underflow), int'(vecs[i].e_uf));
    end

    // Full-depth fill and wrap of the read pointer.
    step(1'b0, 1'b0, 1'b0, 5'b11000);
    step(1'b0, 1'b0, 1'b0, 5'b11000);
    repeat (3) step(1'b1, 1'b0, 1'b0, 5'b11000);
    check("full.rd_count", int'(rd_count), 16);
    check("full.almost_empty", int'(almost_empty), 0);
    check("full.empty", int'(empty), 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'b11000);
      check_model($sformatf("wrap%0d", i));
    end
    check("wrap.b_rd_ptr", int'(b_rd_ptr), 16);
    check("wrap.g_rd_ptr", int'(g_rd_ptr), 24);
    check("wrap.rd_addr", int'(rd_addr), 0);
    check("wrap.empty", int'(empty), 1);

    // Reset after 7 reads of a full FIFO, then refill through the synchroniser.
    step(1'b0, 1'b0, 1'b0, 5'b11000);
    repeat (3) step(1'b1, 1'b0, 1'b0, 5'b11000);
    repeat (7) step(1'b1, 1'b1, 1'b0, 5'b11000);
    check("mid.b_before", int'(b_rd_ptr), 7);
    check("mid.cnt_before", int'(rd_count), 9);
    step(1'b0, 1'b1, 1'b1, 5'b11000);
    check("mid.b_rst", int'(b_rd_ptr), 0);
    check("mid.g_rst", int'(g_rd_ptr), 0);
    check("mid.cnt_rst", int'(rd_count), 0);
    check("mid.empty_rst", int'(empty), 1);
    check("mid.ack_rst", int'(rd_ack), 0);
    step(1'b1, 1'b0, 1'b0, 5'b11000);
    check("mid.idle1_cnt", int'(rd_count), 0);
    step(1'b1, 1'b0, 1'b0, 5'b11000);
    check("mid.idle2_empty", int'(empty), 1);
    step(1'b1, 1'b0, 1'b0, 5'b11000);
    check("mid.refill_cnt", int'(rd_count), 16);
    check("mid.refill_empty", int'(empty), 0);
    check_model("mid");

    // Randomized traffic; write pointer never runs more than one depth ahead.
    step(1'b0, 1'b0, 1'b0, 5'd0);
    w = 0;
    for (int c = 0; c < 1500; c++) begin
      logic r, en, clr;
      logic [4:0] wb;
      r   = ($urandom_range(0, 99) != 0);
      en  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if (!r) w = 0;
      else if ($urandom_range(0, 1) == 1 && ((w - m_rd + MOD) % MOD) < 16) w = (w + 1) % MOD;
      wb = 5'(w);
      step(r, en, clr, wb ^ (wb >> 1));
      check_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rd_ptr_ctrl.md
RD_PTR_CTRL -- requirements
Module: rd_ptr_ctrl

Interface
REQ-001 Parameter PTR_WIDTH, default 4: address width; FIFO depth = 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits.
REQ-002 Parameter SYNC_STAGES, default 2: flop stages on incoming write pointer; legal 2..4.
REQ-003 Parameter AEMPTY_THRESH, default 2: almost-empty threshold in entries; legal 0..2^PTR_WIDTH-1.
REQ-004 rd_clk  in  1  sole clock; all state on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous and active-low.
REQ-006 rd_en  in  1  read request from consumer.
REQ-007 clr_err  in  1  clears sticky underflow flag.
REQ-008 g_wr_ptr  in  PTR_WIDTH+1  Gray write pointer from write domain; unsynchronised.
REQ-009 rd_addr  out  PTR_WIDTH  RAM read address = b_rd_ptr[PTR_WIDTH-1:0].
REQ-010 b_rd_ptr  out  PTR_WIDTH+1  registered binary read pointer.
REQ-011 g_rd_ptr  out  PTR_WIDTH+1  registered Gray read pointer, for the write domain.
REQ-012 empty  out  1  registered empty flag.
REQ-013 almost_empty  out  1  registered; occupancy <= AEMPTY_THRESH.
REQ-014 rd_count  out  PTR_WIDTH+1  registered occupancy as seen by the read side, 0..2^PTR_WIDTH.
REQ-015 rd_ack  out  1  one-cycle pulse; the read accepted on the previous edge.
REQ-016 underflow  out  1  sticky; rd_en was high while empty.

Function
REQ-017 Synchroniser: g_wr_ptr SHALL pass through SYNC_STAGES chained flops; last stage = g_wr_sync.
REQ-018 wr_bin SHALL be the combinational Gray-to-binary conversion of g_wr_sync (MSB-down XOR prefix).
REQ-019 rd_fire = rd_en & ~empty; a read is accepted only when rd_fire is 1.
REQ-020 b_next = b_rd_ptr + rd_fire, modulo 2^(PTR_WIDTH+1); g_next = b_next ^ (b_next >> 1).
REQ-021 Each edge: b_rd_ptr <= b_next, g_rd_ptr <= g_next; exactly one g_rd_ptr bit changes per accepted read.
REQ-022 empty <= (g_next == g_wr_sync); the flag reflects the read taking place in the same cycle.
REQ-023 rd_count <= (wr_bin - b_next) mod 2^(PTR_WIDTH+1).
REQ-024 almost_empty <= ((wr_bin - b_next) mod 2^(PTR_WIDTH+1)) <= AEMPTY_THRESH.
REQ-025 rd_ack <= rd_fire.
REQ-026 underflow <= 1 if (rd_en & empty); else 0 if clr_err; else hold. Set wins over a simultaneous clr_err.
REQ-027 rd_en while empty: no pointer change and no rd_ack; only underflow reacts.
REQ-028 Latency: a g_wr_ptr change held stable is reflected in empty, rd_count and almost_empty SYNC_STAGES+1 edges later.
REQ-029 Wrap-around: the pointer MSB toggles every 2^PTR_WIDTH reads; rd_addr wraps to 0; rd_count SHALL reach 2^PTR_WIDTH when wr_bin - b_rd_ptr = depth.

Reset
REQ-030 On an rd_clk edge with rst_n=0: all synchroniser stages, b_rd_ptr and g_rd_ptr SHALL be set to 0.
REQ-031 On the same edge: empty=1, almost_empty=1, rd_count=0, rd_ack=0 and underflow=0.
REQ-032 Reset SHALL override rd_en and clr_err in the same cycle.
REQ-033 Reset mid-operation SHALL discard the pointers and the occupancy; the block is idle from the first edge after rst_n=1.

Verification (PTR_WIDTH=4, SYNC_STAGES=2, AEMPTY_THRESH=2)
REQ-034 Reset check: rst_n=0 for 2 edges, with rd_en=1 -> empty=1, almost_empty=1, rd_count=0, b_rd_ptr=0, rd_ack=0, underflow=0.
REQ-035 Fill visibility: g_wr_ptr=5'b00010 (bin 3) held -> empty=0, rd_count=3, almost_empty=0 after exactly 3 edges.
REQ-036 Drain: continue from REQ-035 with rd_en=1 for 4 cycles.
- rd_count SHALL step 2, 1, 0; almost_empty=1 from count 2.
- empty=1 after the 3rd read.
- rd_ack SHALL pulse 3 times.
- underflow=1 on the 4th request; b_rd_ptr stays 3.
REQ-037 Error clear: clr_err=1 with rd_en=0 -> underflow=0 next edge; clr_err=1 together with rd_en=1 while empty -> underflow stays 1.
REQ-038 Wrap/full depth: from reset, g_wr_ptr=5'b11000 (bin 16).
- rd_count=16, almost_empty=0.
- 16 reads -> b_rd_ptr=5'b10000, g_rd_ptr=5'b11000, rd_addr=0, empty=1.
REQ-039 Mid-operation reset: in REQ-038, assert rst_n=0 after 7 reads while holding g_wr_ptr.
- Pointers SHALL return to 0.
- After release, rd_count SHALL return to 16 once the synchroniser refills.
